fetch_unit: RTL and testbench

- Instruction fetch stage of the pipelined RV64 core.
- Generates sequential PCs and issues requests to instruction memory over a request/ready and response-valid interface.
- Buffers returned instructions with their PCs in an in-order queue and presents them to the IF/ID pipeline register.
- Honours the hazard-unit stall and EX-stage redirects (branch/jump), discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the pipelined RV64 core.
//
// Sequential PCs are requested from instruction memory. Every accepted
// request reserves a slot in an in-order queue. Responses fill those slots
// in request order, and the head slot drives the IF/ID register.
//
// A redirect from EX flushes the queue and moves the fetch PC. It also
// records how many in-flight responses are now stale, so that they are
// discarded as they arrive.
//
// Handshake rules:
//   imem_req/imem_ready: a request transfers on a cycle where both are
//     high. imem_req may drop without a transfer, for example on a
//     redirect.
//   imem_rvalid: one response per cycle, in request order, with no
//     backpressure. A response with nothing outstanding is ignored.
//   inst_valid/stall: the head entry retires on a cycle with inst_valid=1,
//     stall=0 and redirect=0.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage. Slots are allocated at tail, filled at fill_ptr and
  // retired at head.
  logic [63:0]      q_pc   [DEPTH];
  logic [31:0]      q_inst [DEPTH];
  logic [DEPTH-1:0] q_filled;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] fill_ptr;
  logic [CW-1:0] occ;       // allocated entries, 0..DEPTH
  logic [CW-1:0] pend;      // allocated entries still waiting for data
  logic [CW-1:0] drop_cnt;  // stale responses still to be discarded
  logic [CW-1:0] drop_nxt;
  logic [63:0]   fetch_pc;

  logic          head_valid;
  logic          accept;
  logic          pop;
  logic          rsp_drop;
  logic          rsp_fill;
  logic [CW:0]   budget;

  // Issue control. Stale responses still occupy memory slots, so they
  // count against the queue depth.
  always_comb begin
    budget    = {1'b0, drop_cnt} + {1'b0, occ};
    imem_req  = rst_n && !redirect && (budget < (CW+1)'(DEPTH));
    imem_addr = fetch_pc;
    accept    = imem_req && imem_ready;
  end

  // Head presentation and retire decision. Only registered queue state is
  // used here, so a response that fills the head is visible one cycle later.
  always_comb begin
    head_valid = (occ != '0) && q_filled[head];
    inst_valid = head_valid;
    pc         = (occ != '0) ? q_pc[head] : fetch_pc;
    inst       = head_valid ? q_inst[head] : NOP_INST;
    pop        = head_valid && !stall && !redirect;
  end

  // Response routing. A stale response is discarded. Otherwise the response
  // fills the oldest waiting slot.
  always_comb begin
    rsp_drop = imem_rvalid && (drop_cnt != '0);
    rsp_fill = imem_rvalid && (drop_cnt == '0) && (pend != '0) && !redirect;
  end

  // Drop-count update. On a redirect every outstanding response becomes
  // stale. A response arriving in the same cycle is already dropped here, so
  // it is not counted twice.
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect) begin
      drop_nxt = drop_cnt + pend;
      if (imem_rvalid && ((drop_cnt != '0) || (pend != '0))) begin
        drop_nxt = drop_cnt + pend - CW'(1);
      end
    end else if (rsp_drop) begin
      drop_nxt = drop_cnt - CW'(1);
    end
  end

  // Fetch PC: redirect target word-aligned, otherwise advance on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~64'h3;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 64'd4;
    end
  end

  // Stale-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
    end
  end

  // Queue pointers and counters. A redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      occ      <= '0;
      pend     <= '0;
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      occ      <= '0;
      pend     <= '0;
    end else begin
      if (accept) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (rsp_fill) begin
        fill_ptr <= fill_ptr + PW'(1);
      end
      occ  <= occ + CW'(accept) - CW'(pop);
      pend <= pend + CW'(accept) - CW'(rsp_fill);
    end
  end

  // Per-slot filled flags. Allocation clears the flag and a response sets
  // it. The queue is never full when it accepts, so the allocated slot is
  // never the slot being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_filled <= '0;
    end else begin
      if (accept) begin
        q_filled[tail] <= 1'b0;
      end
      if (rsp_fill) begin
        q_filled[fill_ptr] <= 1'b1;
      end
    end
  end

  // Slot payload. It is only read once occ and q_filled mark it live, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_pc[tail] <= fetch_pc;
    end
    if (rsp_fill) begin
      q_inst[fill_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. An in-order memory with random latency feeds the
// DUT. A reference model tracks the expected instruction stream as a queue
// of PCs per redirect epoch. Every cycle it checks the outputs against that
// model.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        inst_valid;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid)
  );

  // Scoreboard and reference model state.
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];        // PCs requested in this epoch, not yet retired
  int          done_cnt = 0;    // leading exp_q entries whose data has arrived
  logic [63:0] exp_req_pc = RESET_PC;
  int          epoch = 0;

  // Memory model: accepted requests in order, tagged with epoch and due cycle.
  logic [63:0] mem_addr_q[$];
  int          mem_epoch_q[$];
  longint      mem_due_q[$];
  longint      cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  logic        redir_on_rv = 1'b0;
  logic        rv_fired = 1'b0;
  logic [63:0] rv_target = 64'h0;

  function automatic logic [31:0] mk_inst(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5A5A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'h0, inst_valid}, 64'h0);
    check({tag, "_inst"}, {32'h0, inst}, {32'h0, NOP_INST});
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_req"}, {63'h0, imem_req}, 64'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    done_cnt = 0;
    exp_req_pc = RESET_PC;
    mem_addr_q.delete();
    mem_epoch_q.delete();
    mem_due_q.delete();
  endtask

  // One clock cycle. It is entered just after a rising edge with the caller's
  // inputs already set. It drives memory, checks outputs at the falling
  // edge, then advances the model.
  task automatic tick();
    logic        rv;
    logic        ev;
    logic        ereq;
    logic [63:0] epc;
    logic [31:0] einst;
    int          stale;
    int          e;
    rv = 1'b0;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mk_inst(mem_addr_q[0]);
      rv = 1'b1;
    end else if (mem_addr_q.size() == 0 && $urandom_range(0, 7) == 0) begin
      imem_rvalid = 1'b1;  // spurious response with nothing outstanding
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (redir_on_rv && rv) begin
      redirect    = 1'b1;
      redirect_pc = rv_target;
      rv_fired    = 1'b1;
      redir_on_rv = 1'b0;
    end
    @(negedge clk);
    stale = 0;
    foreach (mem_epoch_q[i]) if (mem_epoch_q[i] != epoch) stale++;
    ev    = (done_cnt > 0);
    epc   = (exp_q.size() > 0) ? exp_q[0] : exp_req_pc;
    einst = ev ? mk_inst(epc) : NOP_INST;
    ereq  = !redirect && ((exp_q.size() + stale) < DEPTH);
    check("inst_valid", {63'h0, inst_valid}, {63'h0, ev});
    check("pc", pc, epc);
    check("inst", {32'h0, inst}, {32'h0, einst});
    check("imem_req", {63'h0, imem_req}, {63'h0, ereq});
    if (ereq) check("imem_addr", imem_addr, exp_req_pc);
    // The memory responds to whatever the DUT actually sent.
    if (rv) begin
      e = mem_epoch_q.pop_front();
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
      if (e == epoch && !redirect) done_cnt++;
    end
    if (imem_req && imem_ready) begin
      mem_addr_q.push_back(imem_addr);
      mem_epoch_q.push_back(epoch);
      mem_due_q.push_back(cyc + longint'($urandom_range(lat_min, lat_max)));
    end
    // The reference stream advances on its own expectations.
    if (ereq && imem_ready) begin
      exp_q.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 64'd4;
    end
    if (ev && !stall && !redirect) begin
      void'(exp_q.pop_front());
      done_cnt--;
    end
    if (redirect) begin
      exp_q.delete();
      done_cnt = 0;
      exp_req_pc = redirect_pc & ~64'h3;
      epoch++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Reset state, held across clock edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Streaming with an always-ready, 1-cycle memory.
    imem_ready = 1'b1;
    repeat (20) tick();

    // Stall fill: the queue fills up, then requests stop.
    stall = 1'b1;
    repeat (10) tick();
    stall = 1'b0;
    repeat (12) tick();

    // Redirect with three responses in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 64'h1003;
    tick();
    redirect = 1'b0;
    repeat (15) tick();

    // Redirect in the same cycle as a response, while stalled.
    lat_min = 2; lat_max = 2;
    repeat (3) tick();
    stall = 1'b1;
    rv_target = 64'h2000;
    redir_on_rv = 1'b1;
    for (int i = 0; i < 20 && !rv_fired; i++) tick();
    redirect = 1'b0;
    redir_on_rv = 1'b0;
    check("redirect_on_rvalid_seen", {63'h0, rv_fired}, 64'h1);
    tick();
    stall = 1'b0;
    repeat (10) tick();

    // Back-to-back redirects: the last target wins. The second target also
    // makes the fetch PC wrap past the top of the address space.
    redirect = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
    tick();
    redirect = 1'b0;
    repeat (15) tick();

    // Backpressure pattern on imem_ready.
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 24; i++) begin
      imem_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    imem_ready = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 1600; i++) begin
      if (i % 200 == 0) begin
        lat_min = 1;
        lat_max = 1 + (i / 200) % 5;
      end
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = {$urandom, $urandom};
      imem_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
    repeat (8) tick();

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("async_reset_held");
    rst_n = 1'b1;
    lat_min = 1; lat_max = 3;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
